// File: rtl/fp_instr_encoder.sv
// RV32F instruction encoder: turns an abstract FP ALU request into a 32-bit
// instruction word and buffers {illegal, instr} in a small FIFO.
module fp_instr_encoder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [4:0]  req_rs3,
  input  logic [2:0]  req_rm,
  input  logic [11:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_illegal,
  output logic [7:0]  illegal_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [6:0] OPC_FP     = 7'b1010011;
  localparam logic [6:0] OPC_MADD   = 7'b1000011;
  localparam logic [6:0] OPC_MSUB   = 7'b1000111;
  localparam logic [6:0] OPC_NMSUB  = 7'b1001011;
  localparam logic [6:0] OPC_NMADD  = 7'b1001111;
  localparam logic [6:0] OPC_LOADF  = 7'b0000111;
  localparam logic [6:0] OPC_STOREF = 7'b0100111;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_MUL    = 5'd2;
  localparam logic [4:0] OP_DIV    = 5'd3;
  localparam logic [4:0] OP_SQRT   = 5'd4;
  localparam logic [4:0] OP_MIN    = 5'd5;
  localparam logic [4:0] OP_MAX    = 5'd6;
  localparam logic [4:0] OP_MADD   = 5'd7;
  localparam logic [4:0] OP_MSUB   = 5'd8;
  localparam logic [4:0] OP_NMADD  = 5'd9;
  localparam logic [4:0] OP_NMSUB  = 5'd10;
  localparam logic [4:0] OP_SGNJ   = 5'd11;
  localparam logic [4:0] OP_SGNJN  = 5'd12;
  localparam logic [4:0] OP_SGNJX  = 5'd13;
  localparam logic [4:0] OP_CVTWS  = 5'd14;
  localparam logic [4:0] OP_CVTWUS = 5'd15;
  localparam logic [4:0] OP_CVTSW  = 5'd16;
  localparam logic [4:0] OP_CVTSWU = 5'd17;
  localparam logic [4:0] OP_MVXW   = 5'd18;
  localparam logic [4:0] OP_MVWX   = 5'd19;
  localparam logic [4:0] OP_CLASS  = 5'd20;
  localparam logic [4:0] OP_EQ     = 5'd21;
  localparam logic [4:0] OP_LT     = 5'd22;
  localparam logic [4:0] OP_LE     = 5'd23;
  localparam logic [4:0] OP_FLW    = 5'd24;
  localparam logic [4:0] OP_FSW    = 5'd25;

  typedef struct packed {
    logic        illegal;
    logic [31:0] instr;
  } entry_t;

  // Field-level encoder; every format is assembled as funct7|rs2|rs1|f3|rd|opcode
  logic [6:0]  f7;
  logic [4:0]  rs2_f;
  logic [4:0]  rd_f;
  logic [2:0]  f3;
  logic [6:0]  opc;
  logic        uses_rm;
  logic        known_op;
  logic        rm_bad;
  entry_t      enc;

  always_comb begin
    f7       = 7'b0000000;
    rs2_f    = req_rs2;
    rd_f     = req_rd;
    f3       = req_rm;
    opc      = OPC_FP;
    uses_rm  = 1'b0;
    known_op = 1'b1;
    case (req_op)
      OP_ADD:    begin f7 = 7'b0000000; uses_rm = 1'b1; end
      OP_SUB:    begin f7 = 7'b0000100; uses_rm = 1'b1; end
      OP_MUL:    begin f7 = 7'b0001000; uses_rm = 1'b1; end
      OP_DIV:    begin f7 = 7'b0001100; uses_rm = 1'b1; end
      OP_SQRT:   begin f7 = 7'b0101100; rs2_f = 5'd0; uses_rm = 1'b1; end
      OP_MIN:    begin f7 = 7'b0010100; f3 = 3'b000; end
      OP_MAX:    begin f7 = 7'b0010100; f3 = 3'b001; end
      OP_MADD:   begin f7 = {req_rs3, 2'b00}; opc = OPC_MADD;  uses_rm = 1'b1; end
      OP_MSUB:   begin f7 = {req_rs3, 2'b00}; opc = OPC_MSUB;  uses_rm = 1'b1; end
      OP_NMADD:  begin f7 = {req_rs3, 2'b00}; opc = OPC_NMADD; uses_rm = 1'b1; end
      OP_NMSUB:  begin f7 = {req_rs3, 2'b00}; opc = OPC_NMSUB; uses_rm = 1'b1; end
      OP_SGNJ:   begin f7 = 7'b0010000; f3 = 3'b000; end
      OP_SGNJN:  begin f7 = 7'b0010000; f3 = 3'b001; end
      OP_SGNJX:  begin f7 = 7'b0010000; f3 = 3'b010; end
      OP_CVTWS:  begin f7 = 7'b1100000; rs2_f = 5'd0; uses_rm = 1'b1; end
      OP_CVTWUS: begin f7 = 7'b1100000; rs2_f = 5'd1; uses_rm = 1'b1; end
      OP_CVTSW:  begin f7 = 7'b1101000; rs2_f = 5'd0; uses_rm = 1'b1; end
      OP_CVTSWU: begin f7 = 7'b1101000; rs2_f = 5'd1; uses_rm = 1'b1; end
      OP_MVXW:   begin f7 = 7'b1110000; rs2_f = 5'd0; f3 = 3'b000; end
      OP_MVWX:   begin f7 = 7'b1111000; rs2_f = 5'd0; f3 = 3'b000; end
      OP_CLASS:  begin f7 = 7'b1110000; rs2_f = 5'd0; f3 = 3'b001; end
      OP_EQ:     begin f7 = 7'b1010000; f3 = 3'b010; end
      OP_LT:     begin f7 = 7'b1010000; f3 = 3'b001; end
      OP_LE:     begin f7 = 7'b1010000; f3 = 3'b000; end
      // Memory formats reuse the funct7/rs2/rd slots for the split immediate
      OP_FLW:    begin
        f7 = req_imm[11:5]; rs2_f = req_imm[4:0]; f3 = 3'b010; opc = OPC_LOADF;
      end
      OP_FSW:    begin
        f7 = req_imm[11:5]; rd_f = req_imm[4:0]; f3 = 3'b010; opc = OPC_STOREF;
      end
      default:   known_op = 1'b0;
    endcase
    // rm 101/110 are reserved; 111 (dynamic) is accepted
    rm_bad      = uses_rm && ((req_rm == 3'b101) || (req_rm == 3'b110));
    enc.illegal = !known_op || rm_bad;
    enc.instr   = enc.illegal ? 32'd0 : {f7, rs2_f, req_rs1, f3, rd_f, opc};
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // req_ready depends only on the stored count (no path from out_ready);
  // out_valid is simply "FIFO not empty".
  entry_t           mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign req_ready = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = req_valid && req_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      illegal_cnt <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && enc.illegal && (illegal_cnt != 8'hFF))
        illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

  // Storage needs no reset: the read side is gated by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc;
  end

  assign out_instr   = out_valid ? mem[rd_ptr].instr   : 32'd0;
  assign out_illegal = out_valid ? mem[rd_ptr].illegal : 1'b0;

endmodule

// File: tb/tb_fp_instr_encoder.sv
// Bench for fp_instr_encoder: table-driven encoding model, queue scoreboard
// checked every falling edge, directed literals plus randomized traffic.
module tb_fp_instr_encoder;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic [4:0]  req_rs3 = '0;
  logic [2:0]  req_rm = '0;
  logic [11:0] req_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_illegal;
  logic [7:0]  illegal_cnt;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];
  int unsigned model_cnt = 0;

  // Per-op tables for the OP-FP group (-1: take from request)
  int f7_tab[24]  = '{0, 4, 8, 12, 44, 20, 20, -1, -1, -1, -1, 16, 16, 16,
                      96, 96, 104, 104, 112, 120, 112, 80, 80, 80};
  int f3_tab[24]  = '{-1, -1, -1, -1, -1, 0, 1, -1, -1, -1, -1, 0, 1, 2,
                      -1, -1, -1, -1, 0, 0, 1, 2, 1, 0};
  int rs2_tab[24] = '{-1, -1, -1, -1, 0, -1, -1, -1, -1, -1, -1, -1, -1, -1,
                      0, 1, 0, 1, 0, 0, 0, -1, -1, -1};
  int fused_opc[4] = '{67, 71, 79, 75};

  fp_instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rs3(req_rs3), .req_rm(req_rm), .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] model_enc(int op, int rd, int rs1, int rs2,
                                            int rs3, int rm, int imm);
    longint unsigned w;
    bit rm_used;
    int f3, r2;
    rm_used = 1'b0;
    w = 0;
    if (op > 25) return {1'b1, 32'd0};
    if (op == 24) begin
      w = longint'(imm) * 1048576 + longint'(rs1) * 32768 + 2 * 4096 + rd * 128 + 7;
    end else if (op == 25) begin
      w = longint'(imm / 32) * 33554432 + longint'(rs2) * 1048576 +
          longint'(rs1) * 32768 + 2 * 4096 + (imm % 32) * 128 + 39;
    end else if (op >= 7 && op <= 10) begin
      rm_used = 1'b1;
      w = longint'(rs3) * 134217728 + longint'(rs2) * 1048576 +
          longint'(rs1) * 32768 + rm * 4096 + rd * 128 + fused_opc[op-7];
    end else begin
      f3 = f3_tab[op];
      rm_used = (f3 < 0);
      if (rm_used) f3 = rm;
      r2 = (rs2_tab[op] < 0) ? rs2 : rs2_tab[op];
      w = longint'(f7_tab[op]) * 33554432 + longint'(r2) * 1048576 +
          longint'(rs1) * 32768 + f3 * 4096 + rd * 128 + 83;
    end
    if (rm_used && (rm == 5 || rm == 6)) return {1'b1, 32'd0};
    return {1'b0, w[31:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference model: acts on the same edge as the DUT, from its own queue
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      logic [32:0] e;
      bit do_pop, do_push;
      do_pop  = (exp_q.size() != 0) && out_ready;
      do_push = req_valid && (exp_q.size() < DEPTH);
      e = model_enc(int'(req_op), int'(req_rd), int'(req_rs1), int'(req_rs2),
                    int'(req_rs3), int'(req_rm), int'(req_imm));
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(e);
        if (e[32] && model_cnt < 255) model_cnt++;
      end
    end
  end

  // Compare process: outputs are meaningful on every cycle outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      logic [32:0] head;
      head = (exp_q.size() != 0) ? exp_q[0] : 33'd0;
      check("out_valid",   32'(out_valid),   32'(exp_q.size() != 0));
      check("req_ready",   32'(req_ready),   32'(exp_q.size() < DEPTH));
      check("out_instr",   out_instr,        head[31:0]);
      check("out_illegal", 32'(out_illegal), 32'(head[32]));
      check("illegal_cnt", 32'(illegal_cnt), model_cnt);
    end
  end

  // Caller is at a falling edge; returns at the falling edge after acceptance
  task automatic send(input int op, input int rd, input int rs1, input int rs2,
                      input int rs3, input int rm, input int imm);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1;
    req_op = 5'(op); req_rd = 5'(rd); req_rs1 = 5'(rs1); req_rs2 = 5'(rs2);
    req_rs3 = 5'(rs3); req_rm = 3'(rm); req_imm = 12'(imm);
    for (int t = 0; t < 200 && !ok; t++) begin
      ok = req_ready;
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (!ok) fail_now("send_timeout");
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      if (!out_valid) done = 1'b1;
      else @(negedge clk);
    end
    out_ready = 1'b0;
    if (!done) fail_now("drain_timeout");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_out_valid",   32'(out_valid),   32'd0);
    check("rst_out_instr",   out_instr,        32'd0);
    check("rst_out_illegal", 32'(out_illegal), 32'd0);
    check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // Directed encodings with hand-computed words
    send(0, 1, 2, 3, 0, 0, 0);
    check("fadd_valid", 32'(out_valid), 32'd1);
    check("fadd_instr", out_instr, 32'h003100D3);
    drain();
    send(24, 5, 10, 0, 0, 0, 8);
    check("flw_instr", out_instr, 32'h00852287);
    drain();
    send(7, 4, 1, 2, 3, 7, 0);
    check("fmadd_instr", out_instr, 32'h1820F243);
    drain();
    send(21, 5, 1, 2, 0, 0, 0);
    check("feq_instr", out_instr, 32'hA020A2D3);
    drain();
    send(25, 0, 3, 4, 0, 0, 12'h123);
    check("fsw_instr", out_instr, 32'h1241A1A7);
    drain();

    // Backpressure: two fill the FIFO, the third waits for the consumer
    send(1, 6, 7, 8, 0, 1, 0);
    send(2, 9, 10, 11, 0, 2, 0);
    check("full_req_ready", 32'(req_ready), 32'd0);
    fork
      send(3, 12, 13, 14, 0, 3, 0);
      begin
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Illegal entries between legal ones
    send(0, 1, 1, 1, 0, 0, 0);
    send(27, 2, 2, 2, 0, 0, 0);
    check("ill_cnt_1", 32'(illegal_cnt), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("op27_illegal", 32'(out_illegal), 32'd1);
    check("op27_instr",   out_instr,        32'd0);
    drain();
    send(0, 3, 4, 5, 0, 5, 0);
    check("rm101_illegal", 32'(out_illegal), 32'd1);
    send(11, 6, 7, 8, 0, 5, 0);
    drain();
    check("ill_cnt_2", 32'(illegal_cnt), 32'd2);

    // Asynchronous reset with two entries queued
    send(5, 1, 2, 3, 0, 0, 0);
    send(6, 4, 5, 6, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid",   32'(out_valid),   32'd0);
    check("arst_out_instr",   out_instr,        32'd0);
    check("arst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    send(24, 5, 10, 0, 0, 0, 8);
    check("post_rst_flw", out_instr, 32'h00852287);
    drain();

    // Streaming across pointer wrap
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      int rmv;
      rmv = $urandom_range(0, 5);
      if (rmv == 5) rmv = 7;
      send($urandom_range(0, 25), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31), rmv, $urandom_range(0, 4095));
    end
    drain();

    // Random traffic, mostly legal
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      req_op  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(26, 31))
                                            : 5'($urandom_range(0, 25));
      req_rd  = 5'($urandom); req_rs1 = 5'($urandom); req_rs2 = 5'($urandom);
      req_rs3 = 5'($urandom); req_rm = 3'($urandom); req_imm = 12'($urandom);
      @(negedge clk);
    end

    // Illegal flood to saturate the counter
    req_valid = 1'b1;
    req_op = 5'd31;
    out_ready = 1'b1;
    repeat (260) @(negedge clk);
    req_valid = 1'b0;
    check("ill_cnt_sat", 32'(illegal_cnt), 32'd255);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_instr_encoder.md
Name: fp_instr_encoder

Overview:
- Inverse of the FP decode path: takes an abstract FP operation request (5-bit FP ALU op code plus register indices, rounding mode and immediate) and emits the 32-bit RV32F instruction word.
- Encoded words are buffered in a small FIFO behind valid/ready handshakes.
- Used by the FP self-test sequencer and by the instruction-generation bench to produce legal RV32F streams for the core.
- Op codes are the shared FP ALU control codes 0–23, extended with 24 = FLW and 25 = FSW.

Parameters:
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  encoder can accept a request
- req_op  in  5  operation code (0–25 legal, 26–31 illegal)
- req_rd  in  5  destination register
- req_rs1  in  5  source 1
- req_rs2  in  5  source 2
- req_rs3  in  5  source 3 (fused ops only)
- req_rm  in  3  rounding mode
- req_imm  in  12  FLW/FSW offset
- out_valid  out  1  instruction word available
- out_ready  in  1  consumer takes the word
- out_instr  out  32  encoded instruction
- out_illegal  out  1  request was unencodable; out_instr = 0
- illegal_cnt  out  8  saturating count of illegal requests accepted

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: count = 0, pointers = 0, out_valid = 0, out_instr = 0, out_illegal = 0, illegal_cnt = 0, req_ready = 1 (after release). Reset mid-operation discards all entries immediately (asynchronously).
- Handshake:
  - Push when req_valid && req_ready.
  - Pop when out_valid && out_ready.
  - req_ready = (count < DEPTH). It is registered-state only, with no combinational path from out_ready.
  - Push and pop in the same cycle: count unchanged, both performed, also when full is not asserted.
- Latency: a request accepted at edge k appears at out_instr/out_valid after edge k (visible in cycle k+1). Order is strictly FIFO.
- out_valid = (count != 0). When empty, out_instr = 0 and out_illegal = 0.
- Encoding is combinational at the input; the FIFO stores {illegal, instr[31:0]}. Pointers wrap modulo DEPTH.
- Standard OP-FP format: opcode 1010011, fields funct7|rs2|rs1|f3|rd. rm means f3 = req_rm; fixed rs2 values override req_rs2.
  - 0 ADD: f7 0000000, f3 = rm.
  - 1 SUB: f7 0000100, f3 = rm.
  - 2 MUL: f7 0001000, f3 = rm.
  - 3 DIV: f7 0001100, f3 = rm.
  - 4 SQRT: f7 0101100, rs2 = 0, f3 = rm.
  - 5/6 MIN/MAX: f7 0010100, f3 000/001.
  - 11/12/13 SGNJ/SGNJN/SGNJX: f7 0010000, f3 000/001/010.
  - 14/15 CVT.W.S / CVT.WU.S: f7 1100000, rs2 0/1, f3 = rm.
  - 16/17 CVT.S.W / CVT.S.WU: f7 1101000, rs2 0/1, f3 = rm.
  - 18 MV.X.W: f7 1110000, rs2 0, f3 000.
  - 20 CLASS: f7 1110000, rs2 0, f3 001.
  - 19 MV.W.X: f7 1111000, rs2 0, f3 000.
  - 21/22/23 EQ/LT/LE: f7 1010000, f3 010/001/000.
- Fused ops: [31:27] = rs3, [26:25] = 00, f3 = rm.
  - 7 MADD: opcode 1000011.
  - 8 MSUB: opcode 1000111.
  - 9 NMADD: opcode 1001111.
  - 10 NMSUB: opcode 1001011.
- Memory ops:
  - 24 FLW: imm[11:0] | rs1 | 010 | rd | 0000111.
  - 25 FSW: imm[11:5] | rs2 | rs1 | 010 | imm[4:0] | 0100111.
- Illegal requests (out_illegal = 1, instr = 0):
  - req_op in 26–31.
  - Any rm-using op (0–4, 7–10, 14–17) with req_rm = 101 or 110. rm = 111 (dynamic) is legal.
  - Illegal requests are still accepted and queued in order. illegal_cnt increments on push of an illegal entry and saturates at 255.

Test Plan:
- FADD.S: op 0, rd 1, rs1 2, rs2 3, rm 000 -> one cycle later out_valid = 1, out_instr = 0x003100D3, out_illegal = 0.
- FLW: op 24, rd 5, rs1 10, imm 8 -> 0x00852287. FMADD: op 7, rd 4, rs1 1, rs2 2, rs3 3, rm 111 -> 0x1820F243. FEQ: op 21, rd 5, rs1 1, rs2 2 -> 0xA020A2D3.
- Backpressure, DEPTH 2: out_ready = 0, three back-to-back requests -> req_ready drops after the 2nd accept and the 3rd is held. Then out_ready = 1 -> all three emerge in order; a simultaneous push/pop keeps count at 2.
- Illegal cases: op 27 -> out_illegal = 1, out_instr = 0. FADD with rm 101 -> illegal. illegal_cnt = 2, and neighbouring legal entries are unaffected.
- Reset mid-stream: 2 entries queued, pulse rst_n low between edges -> out_valid = 0 and out_instr = 0 immediately; after release the next request emerges correctly from pointer 0.
- Wrap-around: 9 requests streamed with out_ready = 1 continuously -> one word per cycle, no loss or reorder across pointer wrap.
